u109_pci_burst_buffer: RTL
==========================

Name: u109_pci_burst_buffer

Overview:
Clocked, parametrised successor to the U109 PCI buffer steering logic. Sequences address phase, turnaround and burst data phases between the Amiga-side data bus and the PCI AD bus through a direction-switched FIFO. Applies byte-lane swapping and address-phase formatting. Drives registered enables and directions for the address and level-shifting buffers. Sits in U109 between the PCI cycle state machine and the pins.

Parameters:
DATA_WIDTH, 32, AD/D width in bits; multiple of 8, minimum 16.
FIFO_DEPTH, 4, burst FIFO entries; power of 2, minimum 2.
SWAP_BYTES, 1, 1 = reverse byte lanes between D and AD in both directions; 0 = pass-through.
TURNAROUND, 1, dead cycles between the address phase and the data phase; 0 to 3.

Ports:
CLK40 in 1 system clock; all logic on rising edge.
RESETn in 1 asynchronous, active-low reset.
START in 1 one-cycle pulse that begins a transaction; ignored while BUSY=1.
ABORT in 1 forces a return to IDLE.
BGn in 1 bus owner, latched at START: 0 = CPU is PCI master; 1 = DMA, PCI device is master.
RnW in 1 latched at START.
PCIAT in 2 latched at START: 00 config0, 01 config1, 10 memory, 11 I/O.
A_ADDR in DATA_WIDTH Amiga address, latched at START.
A_DATA_IN in DATA_WIDTH Amiga-side write data.
A_WR in 1 push A_DATA_IN into the FIFO (to-PCI direction only).
A_RD in 1 pop the FIFO head (from-PCI direction only).
A_DATA_OUT out DATA_WIDTH FIFO head; valid while A_EMPTY=0.
A_FULL out 1 FIFO full.
A_EMPTY out 1 FIFO empty.
AD_IN in DATA_WIDTH sampled PCI AD.
AD_OUT out DATA_WIDTH PCI AD drive value.
AD_OE out 1 AD output enable.
PCI_XFER in 1 IRDYn and TRDYn both sampled low this cycle.
LAST in 1 qualifies PCI_XFER as the final data phase.
PCI_ADDR out DATA_WIDTH address captured from AD_IN during a DMA address phase.
ADDRESS_ENn out 1 address buffer enable.
ADDRESS_DIR out 1 address buffer direction; equals the latched BGn.
PCI_BUF_ENn out 1 level-shifter enable.
PCI_BUF_DIR out 1 level-shifter direction.
BUSY out 1 high in any state other than IDLE.
DONE out 1 one-cycle pulse on return to IDLE after a normal completion.
UNDERRUN out 1 sticky error flag; cleared by START.
OVERRUN out 1 sticky error flag; cleared by START.
COUNT out clog2(FIFO_DEPTH)+1 FIFO occupancy.

Behaviour:
- Reset values: state IDLE; AD_OE=0; ADDRESS_ENn=1; PCI_BUF_ENn=1; ADDRESS_DIR=0; PCI_BUF_DIR=0; BUSY, DONE, UNDERRUN, OVERRUN = 0; COUNT=0; AD_OUT, A_DATA_OUT, PCI_ADDR = 0. All outputs are registered.
- Direction TO_PCI = (!BGn && !RnW) || (BGn && RnW), using the values latched at START.
- States are IDLE, ADDR, TA, DATA, TA_END, DRAIN.
- IDLE: on START, latch the inputs, flush the FIFO, clear the sticky flags, go to ADDR.
- ADDR (1 cycle): ADDRESS_ENn=0, PCI_BUF_ENn=0, PCI_BUF_DIR=BGn.
  - BGn=0: AD_OE=1 and AD_OUT is the formatted address.
  - BGn=1: AD_OE=0 and PCI_ADDR<=AD_IN.
  - Next state is TA, or DATA if TURNAROUND=0.
- Address format:
  - memory: {A_ADDR[W-1:2], 2'b10}.
  - config0: {12'h0, A_ADDR[19:2], 2'b00}.
  - config1: {12'h0, A_ADDR[19:2], 2'b01}.
  - I/O: {12'h0, A_ADDR[19:0]}.
  - Upper zero-fill is sized to DATA_WIDTH.
- TA: TURNAROUND cycles with AD_OE=0, ADDRESS_ENn=1, PCI_BUF_ENn=1, then DATA.
- DATA: PCI_BUF_ENn=0, except when BGn=1 in DMA mode it is 1, because PCI-to-PCI traffic does not pass the shifters. PCI_BUF_DIR=TO_PCI.
  - TO_PCI: AD_OE=1, AD_OUT=swap(FIFO head). PCI_XFER with the FIFO non-empty pops the head. PCI_XFER with the FIFO empty sets UNDERRUN and pops nothing.
  - !TO_PCI: AD_OE=0. PCI_XFER pushes swap(AD_IN). PCI_XFER with the FIFO full sets OVERRUN and drops the word.
  - PCI_XFER&&LAST: TO_PCI goes to TA_END; otherwise goes to DRAIN.
- TA_END (1 cycle): AD_OE=0, all enables deasserted, then IDLE with DONE=1.
- DRAIN: AD_OE=0, PCI_BUF_ENn=1. Go to IDLE with DONE=1 on the cycle the FIFO becomes empty. If the FIFO is already empty on entry, go there immediately.
- FIFO rules:
  - A push while full is accepted only if a pop occurs in the same cycle.
  - A pop while empty is ignored, even with a simultaneous push (no fall-through).
  - A_WR outside DATA/TA/ADDR in the TO_PCI direction is ignored.
  - A_RD is legal in DATA and DRAIN.
  - Pointers wrap modulo FIFO_DEPTH.
  - COUNT never exceeds FIFO_DEPTH.
- ABORT: from any non-IDLE state, next cycle goes to IDLE. AD_OE=0, enables deasserted, FIFO flushed, DONE stays 0, sticky flags retained. ABORT and START together in IDLE: ABORT wins.
- An asynchronous reset mid-transaction returns all outputs to their reset values immediately.

Test Plan:
- Memory write, CPU master, DATA_WIDTH=32, SWAP_BYTES=1, TURNAROUND=1:
  - Stimulus: push 0x11223344 and 0x55667788; A_ADDR=0x40001234.
  - Required: ADDR cycle AD_OUT=0x40001236. TA cycle AD_OE=0. Data words AD_OUT=0x44332211, then 0x88776655 on successive PCI_XFER. LAST gives TA_END, then DONE.
- Config0 read, CPU master:
  - Stimulus: A_ADDR=0x000ABCDF; AD_IN 0xDDCCBBAA with PCI_XFER&&LAST.
  - Required: AD_OUT=0x000ABCDC. A_DATA_OUT=0xAABBCCDD. DRAIN holds until A_RD, then DONE.
- DMA read (BGn=1, RnW=1):
  - Stimulus: AD_IN=0x80000010 in ADDR.
  - Required: PCI_ADDR=0x80000010. PCI_BUF_ENn=1 in DATA. AD_OE=1 with FIFO data.
- FIFO_DEPTH=4, from-PCI:
  - Stimulus: 5 PCI_XFER with no A_RD.
  - Required: COUNT=4, A_FULL=1, OVERRUN=1, 5th word lost. Simultaneous A_RD and PCI_XFER at full keeps COUNT=4 with no OVERRUN.
- Underrun and abort:
  - Stimulus: PCI_XFER with an empty FIFO in TO_PCI DATA.
  - Required: UNDERRUN=1. ABORT one cycle later gives IDLE, AD_OE=0, COUNT=0, DONE=0.
- Reset:
  - Stimulus: assert RESETn=0 asynchronously mid-DATA.
  - Required: outputs take reset values before the next CLK40 edge. The next START clears UNDERRUN/OVERRUN.

Source files
------------

// File: rtl/u109_pci_burst_buffer.sv
// u109_pci_burst_buffer
//   Sequences the address phase, turnaround and burst data phases between the Amiga-side
//   data bus and the PCI AD bus through a direction-switched FIFO. Applies byte-lane
//   swapping and address-phase formatting, and drives registered enables/directions for the
//   address and level-shifting buffers.
//
// Ports
//   CLK40, RESETn            clock, asynchronous active-low reset
//   START, ABORT             transaction start pulse / forced return to idle
//   BGn, RnW, PCIAT, A_ADDR  transaction attributes, latched at START
//   A_DATA_IN, A_WR          Amiga-side push (to-PCI direction)
//   A_RD, A_DATA_OUT         Amiga-side pop and FIFO head (from-PCI direction)
//   A_FULL, A_EMPTY, COUNT   FIFO status
//   AD_IN, AD_OUT, AD_OE     PCI AD bus sample / drive / output enable
//   PCI_XFER, LAST           data-phase handshake and final-phase qualifier
//   PCI_ADDR                 address captured during a DMA address phase
//   ADDRESS_ENn/DIR          address buffer controls
//   PCI_BUF_ENn/DIR          level-shifter controls
//   BUSY, DONE               status; DONE pulses on normal completion
//   UNDERRUN, OVERRUN        sticky error flags, cleared by START
module u109_pci_burst_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SWAP_BYTES = 1,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic                          CLK40,
    input  logic                          RESETn,
    input  logic                          START,
    input  logic                          ABORT,
    input  logic                          BGn,
    input  logic                          RnW,
    input  logic [1:0]                    PCIAT,
    input  logic [DATA_WIDTH-1:0]         A_ADDR,
    input  logic [DATA_WIDTH-1:0]         A_DATA_IN,
    input  logic                          A_WR,
    input  logic                          A_RD,
    output logic [DATA_WIDTH-1:0]         A_DATA_OUT,
    output logic                          A_FULL,
    output logic                          A_EMPTY,
    input  logic [DATA_WIDTH-1:0]         AD_IN,
    output logic [DATA_WIDTH-1:0]         AD_OUT,
    output logic                          AD_OE,
    input  logic                          PCI_XFER,
    input  logic                          LAST,
    output logic [DATA_WIDTH-1:0]         PCI_ADDR,
    output logic                          ADDRESS_ENn,
    output logic                          ADDRESS_DIR,
    output logic                          PCI_BUF_ENn,
    output logic                          PCI_BUF_DIR,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          UNDERRUN,
    output logic                          OVERRUN,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int          NB = int'(DATA_WIDTH / 8);
    // Address formatting needs bits [19:0] even for narrow buses.
    localparam int unsigned XW = (DATA_WIDTH > 20) ? DATA_WIDTH : 20;

    typedef enum logic [2:0] {StIdle, StAddr, StTa, StData, StTaEnd, StDrain} state_e;

    state_e                  r_state, w_state_next;

    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_rd_ptr, r_wr_ptr, w_rd_next, w_wr_next;
    logic [CW-1:0]           r_count, w_count_next;
    logic                    r_a_full, r_a_empty;
    logic [DATA_WIDTH-1:0]   r_a_data_out;

    logic                    r_bgn, r_to_pci;
    logic [1:0]              r_ta_cnt;
    logic [DATA_WIDTH-1:0]   r_pci_addr;
    logic                    r_underrun, r_overrun;

    logic                    r_ad_oe, r_address_enn, r_buf_enn, r_buf_dir, r_busy, r_done;
    logic [DATA_WIDTH-1:0]   r_ad_out;

    logic                    w_ad_oe_d, w_address_enn_d, w_buf_enn_d, w_buf_dir_d, w_busy_d;
    logic                    w_done_d;
    logic [DATA_WIDTH-1:0]   w_ad_out_d;

    logic                    w_start, w_flush, w_to_pci_in;
    logic                    w_empty, w_full;
    logic                    w_push_req, w_pop_req, w_push, w_pop;
    logic                    w_underrun_set, w_overrun_set;
    logic [DATA_WIDTH-1:0]   w_push_data, w_head_next, w_fmt_addr;

    function automatic logic [DATA_WIDTH-1:0] f_swap(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] v_s;
        v_s = d;
        if (SWAP_BYTES != 0) begin
            for (int i = 0; i < NB; i++) begin
                v_s[8*i +: 8] = d[8*(NB-1-i) +: 8];
            end
        end
        return v_s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_fmt(input logic [DATA_WIDTH-1:0] addr,
                                                     input logic [1:0] at);
        logic [XW-1:0] v_ax;
        logic [XW-1:0] v_res;
        v_ax = '0;
        v_ax[DATA_WIDTH-1:0] = addr;
        v_res = '0;
        case (at)
            2'b10: begin
                v_res = v_ax;
                v_res[1:0] = 2'b10;
            end
            2'b00: v_res[19:2] = v_ax[19:2];
            2'b01: begin
                v_res[19:2] = v_ax[19:2];
                v_res[0] = 1'b1;
            end
            default: v_res[19:0] = v_ax[19:0];
        endcase
        return v_res[DATA_WIDTH-1:0];
    endfunction

    // ---------------------------------------------------------------- FIFO datapath
    always_comb begin
        w_to_pci_in = (!BGn && !RnW) || (BGn && RnW);
        w_start     = (r_state == StIdle) && START && !ABORT;
        w_flush     = w_start || ((r_state != StIdle) && ABORT);
        w_empty     = (r_count == '0);
        w_full      = (r_count == CW'(FIFO_DEPTH));

        if (r_to_pci) begin
            w_push_req  = A_WR && ((r_state == StAddr) || (r_state == StTa) ||
                                   (r_state == StData));
            w_pop_req   = PCI_XFER && (r_state == StData);
            w_push_data = A_DATA_IN;
        end else begin
            w_push_req  = PCI_XFER && (r_state == StData);
            w_pop_req   = A_RD && ((r_state == StData) || (r_state == StDrain));
            w_push_data = f_swap(AD_IN);
        end

        // No fall-through: a pop on an empty FIFO is dropped even if a push lands.
        w_pop  = w_pop_req && !w_empty && !w_flush;
        w_push = w_push_req && (!w_full || w_pop) && !w_flush;

        w_underrun_set = r_to_pci && (r_state == StData) && PCI_XFER && w_empty && !ABORT;
        w_overrun_set  = !r_to_pci && (r_state == StData) && PCI_XFER && w_full && !w_pop &&
                         !ABORT;

        if (w_flush) begin
            w_rd_next    = '0;
            w_wr_next    = '0;
            w_count_next = '0;
        end else begin
            w_rd_next    = r_rd_ptr + AW'(w_pop);
            w_wr_next    = r_wr_ptr + AW'(w_push);
            w_count_next = r_count + CW'(w_push) - CW'(w_pop);
        end

        // Head after this edge; bypass when the push lands in the head slot.
        if (w_push && (r_wr_ptr == w_rd_next)) begin
            w_head_next = w_push_data;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end

        w_fmt_addr = f_fmt(A_ADDR, PCIAT);
    end

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        w_state_next = r_state;
        if ((r_state != StIdle) && ABORT) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (START && !ABORT) w_state_next = StAddr;
                end
                StAddr: begin
                    w_state_next = (TURNAROUND == 0) ? StData : StTa;
                end
                StTa: begin
                    if (({30'd0, r_ta_cnt} + 32'd1) >= TURNAROUND) w_state_next = StData;
                end
                StData: begin
                    if (PCI_XFER && LAST) w_state_next = r_to_pci ? StTaEnd : StDrain;
                end
                StTaEnd: w_state_next = StIdle;
                StDrain: begin
                    if (w_count_next == '0) w_state_next = StIdle;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM: outputs
    // Values for the state being entered; registered so they line up with that state.
    always_comb begin
        w_busy_d        = (w_state_next != StIdle);
        w_done_d        = !ABORT && (w_state_next == StIdle) &&
                          ((r_state == StTaEnd) || (r_state == StDrain));
        w_ad_oe_d       = 1'b0;
        w_address_enn_d = 1'b1;
        w_buf_enn_d     = 1'b1;
        w_buf_dir_d     = r_buf_dir;
        w_ad_out_d      = r_ad_out;
        case (w_state_next)
            StAddr: begin
                // Only reached from idle, so the live attribute inputs are the latched ones.
                w_address_enn_d = 1'b0;
                w_buf_enn_d     = 1'b0;
                w_buf_dir_d     = BGn;
                w_ad_oe_d       = !BGn;
                if (!BGn) w_ad_out_d = w_fmt_addr;
            end
            StData: begin
                // DMA traffic is PCI-to-PCI and bypasses the level shifters.
                w_buf_enn_d = r_bgn;
                w_buf_dir_d = r_to_pci;
                w_ad_oe_d   = r_to_pci;
                if (r_to_pci) w_ad_out_d = f_swap(w_head_next);
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            r_mem         <= '{default: '0};
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_a_full      <= 1'b0;
            r_a_empty     <= 1'b1;
            r_a_data_out  <= '0;
            r_bgn         <= 1'b0;
            r_to_pci      <= 1'b0;
            r_ta_cnt      <= '0;
            r_pci_addr    <= '0;
            r_underrun    <= 1'b0;
            r_overrun     <= 1'b0;
            r_ad_oe       <= 1'b0;
            r_address_enn <= 1'b1;
            r_buf_enn     <= 1'b1;
            r_buf_dir     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_ad_out      <= '0;
        end else begin
            if (w_push) r_mem[r_wr_ptr] <= w_push_data;
            r_rd_ptr     <= w_rd_next;
            r_wr_ptr     <= w_wr_next;
            r_count      <= w_count_next;
            r_a_full     <= (w_count_next == CW'(FIFO_DEPTH));
            r_a_empty    <= (w_count_next == '0);
            r_a_data_out <= w_head_next;

            if (w_start) begin
                r_bgn    <= BGn;
                r_to_pci <= w_to_pci_in;
            end

            if ((r_state == StTa) && (w_state_next == StTa)) begin
                r_ta_cnt <= r_ta_cnt + 2'd1;
            end else begin
                r_ta_cnt <= '0;
            end

            if ((r_state == StAddr) && r_bgn) r_pci_addr <= AD_IN;

            if (w_start) begin
                r_underrun <= 1'b0;
                r_overrun  <= 1'b0;
            end else begin
                if (w_underrun_set) r_underrun <= 1'b1;
                if (w_overrun_set)  r_overrun  <= 1'b1;
            end

            r_ad_oe       <= w_ad_oe_d;
            r_address_enn <= w_address_enn_d;
            r_buf_enn     <= w_buf_enn_d;
            r_buf_dir     <= w_buf_dir_d;
            r_busy        <= w_busy_d;
            r_done        <= w_done_d;
            r_ad_out      <= w_ad_out_d;
        end
    end

    assign A_DATA_OUT  = r_a_data_out;
    assign A_FULL      = r_a_full;
    assign A_EMPTY     = r_a_empty;
    assign COUNT       = r_count;
    assign AD_OUT      = r_ad_out;
    assign AD_OE       = r_ad_oe;
    assign PCI_ADDR    = r_pci_addr;
    assign ADDRESS_ENn = r_address_enn;
    assign ADDRESS_DIR = r_bgn;
    assign PCI_BUF_ENn = r_buf_enn;
    assign PCI_BUF_DIR = r_buf_dir;
    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign UNDERRUN    = r_underrun;
    assign OVERRUN     = r_overrun;

endmodule
